// File: rtl/fp_conv_pkg.sv
// Shared constants for the fp32 -> fp16 narrowing stage.
// Biases, field widths, special encodings and FSM states.
package fp_conv_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP16_BIAS  = 15;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CONVERT = 1'b1;

endpackage

// File: rtl/fp32_to_fp16_rne.sv
// Combinational binary32 -> binary16 converter.
// Round-to-nearest-even, fp32 subnormal inputs flush to zero.
module fp32_to_fp16_rne
  import fp_conv_pkg::*;
(
  input  logic [31:0] a,
  output logic [15:0] y
);

  logic                               s;
  logic [FP32_EXP_W-1:0]              ex;
  logic [FP32_MAN_W-1:0]              m;
  logic signed [9:0]                  e;

  logic [FP16_EXP_W-1:0]              exp16;
  logic [14:0]                        nrm;
  logic                               nrm_rnd;

  logic [23:0]                        full;
  logic [4:0]                         sh;
  logic [9:0]                         q;
  logic                               sub_g;
  logic                               sub_st;
  logic                               sub_rnd;
  logic [14:0]                        sub;

  logic is_nan, is_inf, is_zero, fin;
  logic ovf, nrm_rng, sub_rng, under;

  assign s  = a[31];
  assign ex = a[30:23];
  assign m  = a[22:0];
  assign e  = $signed({2'b00, ex}) - 10'(FP32_BIAS);

  assign is_nan  = (ex == 8'hFF) && (m != '0);
  assign is_inf  = (ex == 8'hFF) && (m == '0);
  assign is_zero = (ex == 8'h00);
  assign fin     = !is_nan && !is_inf && !is_zero;
  assign ovf     = fin && (e > 10'sd15);
  assign nrm_rng = fin && (e >= -10'sd14) && (e <= 10'sd15);
  assign sub_rng = fin && (e >= -10'sd25) && (e <= -10'sd15);
  assign under   = fin && (e < -10'sd25);

  // mantissa carry ripples into the exponent; 0x7BFF+1 lands on inf
  assign exp16   = 5'(e + 10'(FP16_BIAS));
  assign nrm_rnd = m[12] & ((|m[11:0]) | m[13]);
  assign nrm     = {exp16, m[22:13]} + {14'd0, nrm_rnd};

  // total shift of {1,m} is 13 + (-14-e) = -1-e
  assign full    = {1'b1, m};
  assign sh      = 5'(-10'sd1 - e);
  assign q       = 10'(full >> sh);
  assign sub_g   = |(full & (24'h1 << (sh - 5'd1)));
  assign sub_st  = |(full & ((24'h1 << (sh - 5'd1)) - 24'd1));
  assign sub_rnd = sub_g & (sub_st | q[0]);
  assign sub     = {5'd0, q} + {14'd0, sub_rnd};

  always_comb begin
    y = {s, 15'd0};
    unique case (1'b1)
      is_nan:  y = {s, FP16_QNAN[14:0]};
      is_inf:  y = {s, FP16_INF[14:0]};
      ovf:     y = {s, FP16_INF[14:0]};
      nrm_rng: y = {s, nrm};
      sub_rng: y = {s, sub};
      is_zero: y = {s, 15'd0};
      under:   y = {s, 15'd0};
      default: y = {s, 15'd0};
    endcase
  end

endmodule

// File: rtl/ieee32_to_ieee16_seq.sv
// Sequential fp32 -> fp16 narrowing of NODES elements, one per clock.
// start/busy/done handshake; results land in a registered array.
module ieee32_to_ieee16_seq
  import fp_conv_pkg::*;
#(
  parameter int NODES          = 288,
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NODES*DATA_WIDTH_IN-1:0]  input_fc,
  output logic [NODES*DATA_WIDTH_OUT-1:0] output_fc,
  output logic                            busy,
  output logic                            done
);

  localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;

  logic [0:0]                state;
  logic [IW-1:0]             idx;
  logic [DATA_WIDTH_IN-1:0]  elem;
  logic [DATA_WIDTH_OUT-1:0] res;
  logic                      last;

  assign elem = input_fc[idx*DATA_WIDTH_IN +: DATA_WIDTH_IN];
  assign last = (idx == IW'(NODES-1));

  fp32_to_fp16_rne u_cvt (
    .a (elem),
    .y (res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      output_fc <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CONVERT;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CONVERT: begin
          output_fc[idx*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] <= res;
          if (last) begin
            state <= ST_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee32_to_ieee16_seq.sv
// Bench for ieee32_to_ieee16_seq: directed cases on a 4-element
// instance, random sweep on the 288-element instance.
module tb_ieee32_to_ieee16_seq;

  localparam int N4 = 4;
  localparam int NB = 288;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               start4, startn;
  logic [N4*32-1:0]   in4;
  logic [N4*16-1:0]   out4;
  logic [NB*32-1:0]   inn;
  logic [NB*16-1:0]   outn;
  logic               busy4, done4, busyn, donen;

  int n_cmp = 0;
  int n_err = 0;

  ieee32_to_ieee16_seq #(.NODES(N4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
    .input_fc  (in4),
    .output_fc (out4),
    .busy      (busy4),
    .done      (done4)
  );

  ieee32_to_ieee16_seq #(.NODES(NB)) dutn (
    .clk       (clk),
    .reset     (reset),
    .start     (startn),
    .input_fc  (inn),
    .output_fc (outn),
    .busy      (busyn),
    .done      (donen)
  );

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real pow2(int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic longint rne(real x);
    real    fl, fr;
    longint n;
    fl = $floor(x);
    fr = x - fl;
    n  = longint'(fl);
    if (fr > 0.5 || (fr == 0.5 && n[0])) n++;
    return n;
  endfunction

  function automatic logic [15:0] ref16(logic [31:0] x);
    logic   s;
    int     ex, m, e;
    real    v;
    longint r, bits;
    s  = x[31];
    ex = int'(x[30:23]);
    m  = int'(x[22:0]);
    if (ex == 255) return (m != 0) ? {s, 15'h7E00} : {s, 15'h7C00};
    if (ex == 0) return {s, 15'h0};
    v = (8388608.0 + real'(m)) * pow2(ex - 150);
    if (v >= 65520.0) return {s, 15'h7C00};
    if (v < pow2(-14)) begin
      r = rne(v * pow2(24));
      return {s, 15'(r)};
    end
    e = -14;
    while (v >= pow2(e + 1)) e++;
    r    = rne(v * pow2(10 - e));
    bits = longint'(e + 15) * 1024 + r - 1024;
    return {s, 15'(bits)};
  endfunction

  function automatic logic [127:0] pk32(logic [31:0] a, logic [31:0] b,
                                        logic [31:0] c, logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] pk16(logic [15:0] a, logic [15:0] b,
                                       logic [15:0] c, logic [15:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 7);
    if (sel >= 2 && sel <= 5) w[30:23] = 8'($urandom_range(97, 144));
    if (sel == 6) w[30:23] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
    if (sel == 7) begin
      w[30:23] = 8'($urandom_range(100, 143));
      w[22:0]  = w[22:0] & (23'h7FFFFF << $urandom_range(0, 23));
    end
    return w;
  endfunction

  // ---------------- stimulus helper ----------------
  task automatic run4(input logic [127:0] vin, output int lat,
                      output int bcnt, output int dcnt);
    in4 = vin;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    lat = -1; bcnt = 0; dcnt = 0;
    for (int j = 0; j < 10; j++) begin
      if (busy4) bcnt++;
      if (done4) begin
        dcnt++;
        if (lat < 0) lat = j;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start4 = 1'b0; startn = 1'b0;
    in4 = '0; inn = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out4 !== '0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset4: out=%h busy=%b done=%b expected 0/0/0",
               out4, busy4, done4);
    end
    n_cmp++;
    if (outn !== '0 || busyn !== 1'b0 || donen !== 1'b0) begin
      n_err++;
      $display("FAIL resetN: busy=%b done=%b out_nonzero=%b expected 0/0/0",
               busyn, donen, |outn);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vec4(input string nm, input logic [127:0] vin,
                           input logic [63:0] vexp);
    int lat, bcnt, dcnt;
    run4(vin, lat, bcnt, dcnt);
    for (int i = 0; i < N4; i++) begin
      n_cmp++;
      if (out4[i*16 +: 16] !== vexp[i*16 +: 16]) begin
        n_err++;
        $display("FAIL %s elem%0d: got %h expected %h", nm, i,
                 out4[i*16 +: 16], vexp[i*16 +: 16]);
      end
    end
    n_cmp++;
    if (lat != 4 || bcnt != 4 || dcnt != 1) begin
      n_err++;
      $display("FAIL %s timing: lat=%0d busy=%0d dones=%0d expected 4/4/1",
               nm, lat, bcnt, dcnt);
    end
  endtask

  task automatic test_rounding();
    test_vec4("rounding",
      pk32(32'h3F800000, 32'h3F801000, 32'h3F803000, 32'h477FF000),
      pk16(16'h3C00, 16'h3C00, 16'h3C02, 16'h7C00));
  endtask

  task automatic test_boundaries();
    test_vec4("boundary",
      pk32(32'h477FE000, 32'hB3800000, 32'h33000000, 32'h33000001),
      pk16(16'h7BFF, 16'h8001, 16'h0000, 16'h0001));
  endtask

  task automatic test_specials();
    test_vec4("special",
      pk32(32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00400000),
      pk16(16'h7E00, 16'hFC00, 16'h8000, 16'h0000));
  endtask

  task automatic test_back_to_back();
    logic [63:0] vexp;
    int t1, t2, dc;
    vexp = pk16(16'h7E00, 16'hFC00, 16'h8000, 16'h0000);
    in4 = pk32(32'h3F800000, 32'h3F801000, 32'h3F803000, 32'h477FF000);
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t1 = -1; t2 = -1; dc = 0;
    for (int j = 0; j < 14; j++) begin
      start4 = (j < 2);
      if (done4) begin
        dc++;
        if (dc == 1) begin
          t1 = j;
          in4 = pk32(32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00400000);
          start4 = 1'b1;
        end else if (dc == 2) begin
          t2 = j;
        end
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    n_cmp++;
    if (t1 != 4 || t2 != 9 || dc != 2) begin
      n_err++;
      $display("FAIL handshake: done at %0d,%0d count %0d expected 4,9 count 2",
               t1, t2, dc);
    end
    n_cmp++;
    if (out4 !== vexp) begin
      n_err++;
      $display("FAIL handshake_data: got %h expected %h", out4, vexp);
    end
  endtask

  task automatic test_reset_midop();
    int lat, bcnt, dcnt, act;
    in4 = pk32(32'h3F800000, 32'h3F801000, 32'h3F803000, 32'h477FF000);
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out4 !== '0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_err++;
      $display("FAIL midreset: out=%h busy=%b done=%b expected 0/0/0",
               out4, busy4, done4);
    end
    reset = 1'b0;
    act = 0;
    for (int j = 0; j < 6; j++) begin
      if (busy4 || done4) act++;
      @(negedge clk);
    end
    n_cmp++;
    if (act != 0) begin
      n_err++;
      $display("FAIL midreset_idle: active cycles %0d expected 0", act);
    end
    run4(pk32(32'h477FE000, 32'hB3800000, 32'h33000000, 32'h33000001),
         lat, bcnt, dcnt);
    n_cmp++;
    if (out4 !== pk16(16'h7BFF, 16'h8001, 16'h0000, 16'h0001) || lat != 4) begin
      n_err++;
      $display("FAIL midreset_restart: got %h lat %0d expected %h lat 4",
               out4, lat, pk16(16'h7BFF, 16'h8001, 16'h0000, 16'h0001));
    end
  endtask

  task automatic test_random_sweep();
    logic [15:0] expv [NB];
    logic [31:0] w;
    int lat;
    for (int t = 0; t < 35; t++) begin
      for (int i = 0; i < NB; i++) begin
        w = rnd_word();
        inn[i*32 +: 32] = w;
        expv[i] = ref16(w);
      end
      @(negedge clk);
      startn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      startn = 1'b0;
      lat = -1;
      for (int j = 0; j < 400 && lat < 0; j++) begin
        if (donen) lat = j;
        else @(negedge clk);
      end
      n_cmp++;
      if (lat != NB) begin
        n_err++;
        $display("FAIL sweep_latency t%0d: got %0d expected %0d", t, lat, NB);
      end
      for (int i = 0; i < NB; i++) begin
        n_cmp++;
        if (outn[i*16 +: 16] !== expv[i]) begin
          n_err++;
          $display("FAIL sweep t%0d elem%0d in=%h: got %h expected %h",
                   t, i, inn[i*32 +: 32], outn[i*16 +: 16], expv[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_boundaries();
    test_specials();
    test_back_to_back();
    test_reset_midop();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ieee32_to_ieee16_seq.md
Name: ieee32_to_ieee16_seq

Overview:
Sequential converter from packed IEEE-754 binary32 to packed IEEE-754 binary16. It converts NODES elements, one per clock, with round-to-nearest-even. It is the reverse of the fp16→fp32 widening stage between the convolution stack and the fully-connected network. It narrows fp32 results, such as FC-layer activations or host-side weights, back into the 16-bit datapath used by the convolution engines. A start/busy/done handshake lets the top-level sequencer replace fixed cycle-count reset timing.

Parameters:
NODES, 288, number of elements converted per transaction (3*3*32).
DATA_WIDTH_IN, 32, input element width (binary32); fixed, not overridable in practice.
DATA_WIDTH_OUT, 16, output element width (binary16); fixed.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk only.
start  input  1  single-cycle request; honoured only in IDLE.
input_fc  input  NODES*32  packed fp32 elements; element i at bits [i*32 +: 32]; must be held stable while busy=1.
output_fc  output  NODES*16  packed fp16 results; element i at bits [i*16 +: 16]; registered.
busy  output  1  high while converting.
done  output  1  one-cycle pulse when all NODES results are valid.

Behaviour:
- Reset (at a clock edge with reset=1):
  - FSM goes to IDLE, element index to 0.
  - output_fc=0, busy=0, done=0.
  - This applies equally mid-transaction: the partial result is discarded and there is no resume.
- FSM states are IDLE and CONVERT.
- IDLE:
  - start=1 at an edge → CONVERT, idx=0, busy=1.
  - done is cleared at every edge not explicitly setting it.
- CONVERT, at each edge:
  - output_fc[idx] ← f(input_fc[idx]), then idx+1.
  - When idx==NODES-1: that write occurs, busy←0, done←1, state→IDLE, idx←0.
- Timing:
  - start accepted at edge k → last write and done=1 both appear after edge k+NODES.
  - done drops after edge k+NODES+1.
  - Back-to-back start is allowed in the cycle where done=1 (state is already IDLE).
- start while busy=1 is ignored; no queueing.
- Elements not yet rewritten in a new transaction keep their previous values until overwritten.
- Conversion f, with sign s copied in all cases:
  - exp32=255, mant≠0 → canonical quiet NaN {s,0x7E00[14:0]}.
  - exp32=255, mant=0 → ±inf {s,5'h1F,10'h0}.
  - exp32=0 (zero or fp32 subnormal) → ±0.
  - Otherwise e=exp32-127:
    - e>15 → ±inf.
    - -14≤e≤15 → exp16=e+15, mant16=mant32[22:13]. Round RNE using guard=mant32[12] and sticky=|mant32[11:0]. A mantissa carry increments exp16; exp16 reaching 31 → ±inf.
    - -25≤e≤-15 → subnormal. Shift {1,mant32} right by (-14-e) into a 10-bit field, then RNE using guard/sticky from the shifted-out bits. A carry into bit 10 yields min normal 0x0400.
    - e<-25 → ±0.
- f is purely combinational within the CONVERT cycle; no multicycle paths.

Decomposition:
- Package fp_conv_pkg holds:
  - FP32_BIAS=127 and FP16_BIAS=15.
  - FP16_INF=16'h7C00 and FP16_QNAN=16'h7E00.
  - Field-width constants.
  - FSM state encoding.
- Sub-module fp32_to_fp16_rne: a purely combinational single-element converter (32-bit in, 16-bit out). The top module holds the FSM, idx counter, element mux and output register array.

Test Plan:
1. Rounding and overflow, NODES=4, input {0x3F800000, 0x3F801000, 0x3F803000, 0x477FF000}, one start pulse:
   - output {0x3C00, 0x3C00, 0x3C02, 0x7C00}.
   - busy high 4 cycles; done pulses exactly once, 4 cycles after the start edge.
2. Largest finite and subnormal boundaries, input {0x477FE000, 0xB3800000, 0x33000000, 0x33000001} → {0x7BFF, 0x8001, 0x0000, 0x0001}.
3. Special values, input {0x7FC00000, 0xFF800000, 0x80000000, 0x00400000} → {0x7E00, 0xFC00, 0x8000, 0x0000}.
4. Handshake:
   - start re-asserted on cycles 1 and 2 while busy → ignored; one done only.
   - start in the done cycle → second transaction begins; its done comes NODES cycles later.
5. Reset mid-op: reset=1 on cycle 2 of a 4-element transaction → next cycle output_fc=0, busy=0, done=0, FSM in IDLE. A fresh start then completes normally.
6. Randomised sweep: 10k random fp32 words through NODES=288 transactions, compared bit-exactly against a reference RNE model; done latency is always 288.
